// File: rtl/n_term_loopback_pipe.sv
// rtl/n_term_loopback_pipe.sv - north-edge terminal tile with configurable loopback and strobe monitor
//
// Purpose:
//    Sits at the top of a RAM_IO column. Every incoming N* wire is turned back south on the
//    same index. The loopback path is selectable through ConfigBits:
//       00 combinational, 01 PIPE_DEPTH-registered, 10 tie-0, 11 tie-1.
//    A mode change drains the tile, which holds S*BEG at 0 for PIPE_DEPTH edges.
//    A monitor flags any multi-hot FrameStrobe pattern, using a sticky flag and a saturating
//    counter.
//
// Ports:
//    UserCLK / resetn             clock and asynchronous active-low reset
//    UserCLKo                     UserCLK passed through
//    FrameStrobe / FrameStrobe_O  config strobes passed through combinationally
//    ConfigBits                   loopback mode select
//    N1END, N2MID, N2END, N4END   incoming wires
//    S1BEG, S2BEG, S2BEGb, S4BEG  loopback outputs
//    StrobeErrClr                 synchronous clear of StrobeErr / StrobeErrCnt
//    StrobeErr, StrobeErrCnt      sticky multi-hot flag and saturating event count
module n_term_loopback_pipe #(
   parameter int MaxFramesPerCol = 20,
   parameter int N1_WIRES        = 4,
   parameter int N2_WIRES        = 8,
   parameter int N4_WIRES        = 16,
   parameter int PIPE_DEPTH      = 2,
   parameter int ERR_CNT_W       = 8
) (
   input  logic                       UserCLK,
   input  logic                       resetn,
   output logic                       UserCLKo,
   input  logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
   input  logic [1:0]                 ConfigBits,
   input  logic [N1_WIRES-1:0]        N1END,
   input  logic [N2_WIRES-1:0]        N2MID,
   input  logic [N2_WIRES-1:0]        N2END,
   input  logic [N4_WIRES-1:0]        N4END,
   output logic [N1_WIRES-1:0]        S1BEG,
   output logic [N2_WIRES-1:0]        S2BEG,
   output logic [N2_WIRES-1:0]        S2BEGb,
   output logic [N4_WIRES-1:0]        S4BEG,
   input  logic                       StrobeErrClr,
   output logic                       StrobeErr,
   output logic [ERR_CNT_W-1:0]       StrobeErrCnt
);

   localparam int TOT_W = N1_WIRES + 2 * N2_WIRES + N4_WIRES;
   localparam int CNT_W = 3;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   localparam logic [1:0] MODE_COMB = 2'b00;
   localparam logic [1:0] MODE_PIPE = 2'b01;
   localparam logic [1:0] MODE_TIE1 = 2'b11;

   logic [1:0]                      mode_q, mode_d;
   logic [0:0]                      state_q, state_d;
   logic [CNT_W-1:0]                drain_cnt_q, drain_cnt_d;
   logic [PIPE_DEPTH-1:0][TOT_W-1:0] pipe_q, pipe_d;
   logic                            err_q, err_d;
   logic [ERR_CNT_W-1:0]            err_cnt_q, err_cnt_d;
   logic [TOT_W-1:0]                n_bus;
   logic [TOT_W-1:0]                s_bus;
   logic                            multi;

   // Clock and strobes are plain feed-throughs; reset does not touch them.
   assign UserCLKo      = UserCLK;
   assign FrameStrobe_O = FrameStrobe;

   assign n_bus = {N4END, N2END, N2MID, N1END};

   // Clearing the lowest set bit leaves a non-zero value only when two or more bits are set.
   assign multi = (FrameStrobe & (FrameStrobe - MaxFramesPerCol'(1))) != '0;

   always_comb begin
      mode_d      = ConfigBits;
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      pipe_d[0]   = n_bus;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      if (ConfigBits != mode_q) begin
         // A mode change restarts the drain, even when a drain is already in progress.
         pipe_d      = '0;
         drain_cnt_d = CNT_W'(PIPE_DEPTH);
         state_d     = ST_DRAIN;
      end else if (state_q == ST_DRAIN && drain_cnt_q != '0) begin
         drain_cnt_d = drain_cnt_q - CNT_W'(1);
         if (drain_cnt_d == '0) begin
            state_d = ST_RUN;
         end
      end
   end

   always_comb begin
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      if (StrobeErrClr) begin
         // A clear that lands on a multi-hot edge still records that edge.
         err_d     = multi;
         err_cnt_d = multi ? ERR_CNT_W'(1) : '0;
      end else if (multi) begin
         err_d = 1'b1;
         if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         mode_q      <= MODE_COMB;
         state_q     <= ST_DRAIN;
         drain_cnt_q <= CNT_W'(PIPE_DEPTH);
         pipe_q      <= '0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         mode_q      <= mode_d;
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         pipe_q      <= pipe_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // The output is 0 throughout the drain, whatever the mode.
   always_comb begin
      s_bus = '0;
      if (state_q == ST_RUN) begin
         case (mode_q)
            MODE_COMB: s_bus = n_bus;
            MODE_PIPE: s_bus = pipe_q[PIPE_DEPTH-1];
            MODE_TIE1: s_bus = '1;
            default:   s_bus = '0;
         endcase
      end
   end

   assign {S4BEG, S2BEGb, S2BEG, S1BEG} = s_bus;
   assign StrobeErr    = err_q;
   assign StrobeErrCnt = err_cnt_q;

endmodule

// File: tb/tb_n_term_loopback_pipe.sv
// tb/tb_n_term_loopback_pipe.sv - directed self-checking bench for n_term_loopback_pipe
module tb_n_term_loopback_pipe;

   logic        clk;
   logic        resetn;
   logic        clr;
   logic [19:0] fs;
   logic [1:0]  cfg;
   logic [3:0]  n1;
   logic [7:0]  n2m;
   logic [7:0]  n2e;
   logic [15:0] n4;

   logic        clko,  clko2;
   logic [19:0] fs_o,  fs_o2;
   logic [3:0]  s1,    s1_2;
   logic [7:0]  s2,    s2_2;
   logic [7:0]  s2b,   s2b_2;
   logic [15:0] s4,    s4_2;
   logic        err,   err2;
   logic [7:0]  cnt;
   logic [1:0]  cnt2;

   int checks = 0;
   int passes = 0;

   n_term_loopback_pipe dut (
      .UserCLK(clk), .resetn(resetn), .UserCLKo(clko),
      .FrameStrobe(fs), .FrameStrobe_O(fs_o), .ConfigBits(cfg),
      .N1END(n1), .N2MID(n2m), .N2END(n2e), .N4END(n4),
      .S1BEG(s1), .S2BEG(s2), .S2BEGb(s2b), .S4BEG(s4),
      .StrobeErrClr(clr), .StrobeErr(err), .StrobeErrCnt(cnt)
   );

   n_term_loopback_pipe #(.ERR_CNT_W(2)) dut_sat (
      .UserCLK(clk), .resetn(resetn), .UserCLKo(clko2),
      .FrameStrobe(fs), .FrameStrobe_O(fs_o2), .ConfigBits(cfg),
      .N1END(n1), .N2MID(n2m), .N2END(n2e), .N4END(n4),
      .S1BEG(s1_2), .S2BEG(s2_2), .S2BEGb(s2b_2), .S4BEG(s4_2),
      .StrobeErrClr(clr), .StrobeErr(err2), .StrobeErrCnt(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; clr = 1'b0; cfg = 2'b00; fs = 20'h00010;
      n1 = 4'h6; n2m = 8'h3C; n2e = 8'hC3; n4 = 16'hA5C3;
      repeat (3) tick();
      checks++; if (s4 !== 16'h0) $display("FAIL rst_s4: got %h want %h", s4, 16'h0); else passes++;
      checks++; if (s1 !== 4'h0) $display("FAIL rst_s1: got %h want %h", s1, 4'h0); else passes++;
      checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want %b", err, 1'b0); else passes++;
      checks++; if (cnt !== 8'h0) $display("FAIL rst_cnt: got %h want %h", cnt, 8'h0); else passes++;
      checks++; if (fs_o !== 20'h00010) $display("FAIL rst_fs_o: got %h want %h", fs_o, 20'h00010); else passes++;
      checks++; if (clko !== 1'b1) $display("FAIL rst_clko: got %b want %b", clko, 1'b1); else passes++;
      resetn = 1'b1;
      #1;
      checks++; if (s4 !== 16'h0) $display("FAIL drain_e0: got %h want %h", s4, 16'h0); else passes++;
      tick();
      checks++; if (s4 !== 16'h0) $display("FAIL drain_e1: got %h want %h", s4, 16'h0); else passes++;
      tick();
      checks++; if (s4 !== 16'hA5C3) $display("FAIL run_s4: got %h want %h", s4, 16'hA5C3); else passes++;
      checks++; if (s1 !== 4'h6) $display("FAIL run_s1: got %h want %h", s1, 4'h6); else passes++;
      checks++; if (s2 !== 8'h3C) $display("FAIL run_s2: got %h want %h", s2, 8'h3C); else passes++;
      checks++; if (s2b !== 8'hC3) $display("FAIL run_s2b: got %h want %h", s2b, 8'hC3); else passes++;
      n4 = 16'h1234;
      #1;
      checks++; if (s4 !== 16'h1234) $display("FAIL comb_s4: got %h want %h", s4, 16'h1234); else passes++;
   endtask

   task automatic test_piped();
      cfg = 2'b01; n1 = 4'h0;
      tick();
      n1 = 4'h5;
      checks++; if (s1 !== 4'h0) $display("FAIL pipe_drain_a: got %h want %h", s1, 4'h0); else passes++;
      checks++; if (s4 !== 16'h0) $display("FAIL pipe_drain_s4: got %h want %h", s4, 16'h0); else passes++;
      tick();
      n1 = 4'h0;
      checks++; if (s1 !== 4'h0) $display("FAIL pipe_drain_b: got %h want %h", s1, 4'h0); else passes++;
      tick();
      checks++; if (s1 !== 4'h5) $display("FAIL pipe_first_run: got %h want %h", s1, 4'h5); else passes++;
      n1 = 4'h9;
      tick();
      n1 = 4'h0;
      checks++; if (s1 !== 4'h0) $display("FAIL pipe_lat1: got %h want %h", s1, 4'h0); else passes++;
      tick();
      checks++; if (s1 !== 4'h9) $display("FAIL pipe_lat2: got %h want %h", s1, 4'h9); else passes++;
      tick();
      checks++; if (s1 !== 4'h0) $display("FAIL pipe_after: got %h want %h", s1, 4'h0); else passes++;
   endtask

   task automatic test_mid_drain();
      cfg = 2'b10;
      repeat (3) tick();
      checks++; if (s4 !== 16'h0) $display("FAIL tie0_s4: got %h want %h", s4, 16'h0); else passes++;
      cfg = 2'b01;
      tick();
      cfg = 2'b11;
      checks++; if (s4 !== 16'h0) $display("FAIL md_e0: got %h want %h", s4, 16'h0); else passes++;
      tick();
      checks++; if (s4 !== 16'h0) $display("FAIL md_e1: got %h want %h", s4, 16'h0); else passes++;
      tick();
      checks++; if (s4 !== 16'h0) $display("FAIL md_restart: got %h want %h", s4, 16'h0); else passes++;
      tick();
      checks++; if (s4 !== 16'hFFFF) $display("FAIL tie1_s4: got %h want %h", s4, 16'hFFFF); else passes++;
      checks++; if (s1 !== 4'hF) $display("FAIL tie1_s1: got %h want %h", s1, 4'hF); else passes++;
      checks++; if (s2 !== 8'hFF) $display("FAIL tie1_s2: got %h want %h", s2, 8'hFF); else passes++;
      checks++; if (s2b !== 8'hFF) $display("FAIL tie1_s2b: got %h want %h", s2b, 8'hFF); else passes++;
   endtask

   task automatic test_strobe_err();
      fs = 20'h00003;
      #1;
      checks++; if (fs_o !== 20'h00003) $display("FAIL se_fs_o: got %h want %h", fs_o, 20'h00003); else passes++;
      checks++; if (err !== 1'b0) $display("FAIL se_pre: got %b want %b", err, 1'b0); else passes++;
      tick();
      checks++; if (cnt !== 8'd1) $display("FAIL se_cnt1: got %0d want %0d", cnt, 1); else passes++;
      tick();
      tick();
      checks++; if (err !== 1'b1) $display("FAIL se_err: got %b want %b", err, 1'b1); else passes++;
      checks++; if (cnt !== 8'd3) $display("FAIL se_cnt3: got %0d want %0d", cnt, 3); else passes++;
      fs = 20'h80000;
      tick();
      checks++; if (cnt !== 8'd3) $display("FAIL se_onehot: got %0d want %0d", cnt, 3); else passes++;
      fs = 20'h0; clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (err !== 1'b0) $display("FAIL clr_err: got %b want %b", err, 1'b0); else passes++;
      checks++; if (cnt !== 8'd0) $display("FAIL clr_cnt: got %0d want %0d", cnt, 0); else passes++;
      checks++; if (cnt2 !== 2'd0) $display("FAIL clr_cnt2: got %0d want %0d", cnt2, 0); else passes++;
   endtask

   task automatic test_sat_clear();
      fs = 20'hF0000;
      repeat (5) tick();
      checks++; if (cnt2 !== 2'd3) $display("FAIL sat_cnt2: got %0d want %0d", cnt2, 3); else passes++;
      checks++; if (err2 !== 1'b1) $display("FAIL sat_err2: got %b want %b", err2, 1'b1); else passes++;
      checks++; if (cnt !== 8'd5) $display("FAIL sat_cnt8: got %0d want %0d", cnt, 5); else passes++;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (cnt2 !== 2'd1) $display("FAIL clrmulti_cnt2: got %0d want %0d", cnt2, 1); else passes++;
      checks++; if (err2 !== 1'b1) $display("FAIL clrmulti_err2: got %b want %b", err2, 1'b1); else passes++;
      checks++; if (cnt !== 8'd1) $display("FAIL clrmulti_cnt8: got %0d want %0d", cnt, 1); else passes++;
      tick();
      checks++; if (cnt2 !== 2'd2) $display("FAIL post_clr_cnt2: got %0d want %0d", cnt2, 2); else passes++;
      fs = 20'h0;
   endtask

   task automatic test_async_reset();
      cfg = 2'b01; n4 = 16'hBEEF; n1 = 4'hA;
      repeat (3) tick();
      checks++; if (s4 !== 16'hBEEF) $display("FAIL ar_pre_s4: got %h want %h", s4, 16'hBEEF); else passes++;
      checks++; if (s1 !== 4'hA) $display("FAIL ar_pre_s1: got %h want %h", s1, 4'hA); else passes++;
      fs = 20'h00003;
      tick();
      fs = 20'h00000;
      checks++; if (err !== 1'b1) $display("FAIL ar_pre_err: got %b want %b", err, 1'b1); else passes++;
      #2;
      resetn = 1'b0;
      #1;
      checks++; if (s4 !== 16'h0) $display("FAIL ar_s4: got %h want %h", s4, 16'h0); else passes++;
      checks++; if (s1 !== 4'h0) $display("FAIL ar_s1: got %h want %h", s1, 4'h0); else passes++;
      checks++; if (s2b !== 8'h0) $display("FAIL ar_s2b: got %h want %h", s2b, 8'h0); else passes++;
      checks++; if (err !== 1'b0) $display("FAIL ar_err: got %b want %b", err, 1'b0); else passes++;
      checks++; if (cnt !== 8'd0) $display("FAIL ar_cnt: got %0d want %0d", cnt, 0); else passes++;
      tick();
      resetn = 1'b1;
   endtask

   initial begin
      test_reset();
      test_piped();
      test_mid_drain();
      test_strobe_err();
      test_sat_clear();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
